uop_sequencer: RTL
==================

// Module: uop_sequencer
// PURPOSE
// - Single-clock FSM replacing the 8-phase clock generator as the CPU's control unit.
// - Sequences fetch -> decode -> per-micro-op (select -> execute -> writeback).
// - Micro-op count per instruction comes from decode's num_of_ope.
// - Drives one-hot stage enables to fetch, decode, selector, alu and register/stack writeback.
// - Counts retired instructions; handles halt requests, fetch wait states and fault detection.
// PARAMETERS
// - MAX_UOPS       2    largest legal num_of_ope; larger values or 0 are faults
// - FETCH_TIMEOUT  15   max wait cycles in FETCH for mem_ready before fault (1..255)
// - RET_W          16   width of retired-instruction counter
// PORTS
// - clk          in   1      system clock; all state changes on rising edge
// - reset        in   1      synchronous, active-high
// - mem_ready    in   1      fetch data valid this cycle
// - num_of_ope   in   4      micro-op count from decode; valid the cycle after decode_en
// - halt_req     in   1      level; honoured only at instruction boundaries
// - fetch_en     out  1      fetch stage enable
// - decode_en    out  1      decode stage enable
// - select_en    out  1      operand selector enable
// - exec_en      out  1      alu enable
// - wb_en        out  1      register/stack write enable
// - uop_sel      out  1      0 = first micro-op, 1 = second; drives select/result muxing
// - retire       out  1      1-cycle pulse in the last WRITEBACK of an instruction
// - retired_cnt  out  RET_W  retired instructions; wraps modulo 2^RET_W
// - halted       out  1      FSM in HALTED
// - fault        out  1      FSM in FAULT; sticky until reset
// BEHAVIOUR
// - Outputs decode the state register (Moore); no combinational input->output path.
// - Reset: state=IDLE; uop_sel=0; retired_cnt=0; uop count=0; wait counter=0.
//   All enables, retire, halted and fault are 0.
// - Reset mid-operation takes effect at the next edge from any state; no retire pulse or count.
// - States: IDLE, FETCH, DECODE, SELECT, EXECUTE, WRITEBACK, HALTED, FAULT.
// - IDLE: go to HALTED if halt_req, else FETCH.
// - FETCH: fetch_en=1.
//   - mem_ready -> DECODE and clear the wait counter.
//   - Else increment the wait counter; leaving FETCH_TIMEOUT waits -> FAULT.
//   - mem_ready on the timeout cycle wins -> DECODE.
// - DECODE: decode_en=1 for one cycle -> SELECT; uop_sel=0.
// - SELECT: select_en=1.
//   - On first entry per instruction, latch num_of_ope.
//   - If latched value is 0 or > MAX_UOPS -> FAULT; no enables downstream.
//   - Otherwise -> EXECUTE.
// - EXECUTE: exec_en=1 -> WRITEBACK.
// - WRITEBACK: wb_en=1.
//   - If uop_sel+1 < uop count: uop_sel++ and go to SELECT; count is not re-latched.
//   - Otherwise retire=1 and retired_cnt++.
//     - halt_req -> HALTED.
//     - Else -> FETCH, with uop_sel cleared.
// - Latency with mem_ready=1 at once: 1-uop instruction = 5 cycles; 2-uop = 8 cycles.
//   retire pulses every 5 or 8 cycles back-to-back.
// - halt_req mid-instruction: ignored until the retiring WRITEBACK.
// - halt_req with retire in the same cycle: the retire is counted, then HALTED.
// - HALTED: halted=1; leave to FETCH the cycle after halt_req is sampled 0.
// - FAULT: fault=1; all enables 0; exit only via reset.
// - retired_cnt at 2^RET_W-1 plus one retire -> 0, with no flag.
// CONFIGURATION
// - SEQ_SINGLE_STEP_EN defined:
//   - Adds input step_req (1 bit).
//   - A retiring WRITEBACK without halt_req goes to state PAUSE (all enables 0, halted=0).
//   - PAUSE -> FETCH on the cycle after step_req=1; halt_req in PAUSE -> HALTED.
// - SEQ_SINGLE_STEP_EN undefined:
//   - step_req port and PAUSE state are absent.
//   - Retire goes straight to FETCH.
// TESTING
// - Reset 2 cycles, mem_ready=1, num_of_ope=1 ->
//   enables fetch, decode, select, exec, wb one cycle each; retire at cycle 5; retired_cnt=1.
// - num_of_ope=2 ->
//   select/exec/wb twice, uop_sel 0 then 1; one retire at cycle 8; retired_cnt +1.
// - mem_ready held 0 with FETCH_TIMEOUT=3 -> fault=1 after 4 FETCH cycles;
//   remains until reset.
// - mem_ready low 2 cycles -> FETCH lasts 3 cycles, no fault.
// - num_of_ope=0, and separately num_of_ope=3 -> FAULT from SELECT; exec_en never asserts.
// - halt_req raised in EXECUTE ->
//   WRITEBACK completes, retire counted, halted=1; FETCH 1 cycle after halt_req drops.
// - reset pulsed during 2nd-uop EXECUTE -> next cycle IDLE, retired_cnt=0, no retire.
// - retired_cnt preloaded (RET_W=4) at 15 + one retire -> 0.
// - SEQ_SINGLE_STEP_EN: after retire FSM sits in PAUSE;
//   step_req pulse -> FETCH next cycle.

Source files
------------

// File: rtl/uop_sequencer_if.sv
// Stage-enable and fetch/decode handshake bundle between the sequencer and the datapath.
// The step_req input exists only when SEQ_SINGLE_STEP_EN is defined.
interface uop_seq_if #(
    parameter int RET_W = 16
);
    logic             mem_ready;
    logic [3:0]       num_of_ope;
    logic             halt_req;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step_req;
`endif
    logic             fetch_en;
    logic             decode_en;
    logic             select_en;
    logic             exec_en;
    logic             wb_en;
    logic             uop_sel;
    logic             retire;
    logic [RET_W-1:0] retired_cnt;
    logic             halted;
    logic             fault;

    modport slave (
        input  mem_ready, num_of_ope, halt_req,
`ifdef SEQ_SINGLE_STEP_EN
        input  step_req,
`endif
        output fetch_en, decode_en, select_en, exec_en, wb_en,
        output uop_sel, retire, retired_cnt, halted, fault
    );

    modport master (
        output mem_ready, num_of_ope, halt_req,
`ifdef SEQ_SINGLE_STEP_EN
        output step_req,
`endif
        input  fetch_en, decode_en, select_en, exec_en, wb_en,
        input  uop_sel, retire, retired_cnt, halted, fault
    );
endinterface

// File: rtl/uop_sequencer.sv
// Single-clock control FSM: fetch -> decode -> (select -> execute -> writeback) per micro-op.
// Optional single-step PAUSE state enabled by defining SEQ_SINGLE_STEP_EN.
module uop_sequencer #(
    parameter int MAX_UOPS      = 2,
    parameter int FETCH_TIMEOUT = 15,
    parameter int RET_W         = 16
) (
    input logic       clk,
    input logic       reset,
    uop_seq_if.slave  bus
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_SELECT    = 4'd3;
    localparam logic [3:0] S_EXECUTE   = 4'd4;
    localparam logic [3:0] S_WRITEBACK = 4'd5;
    localparam logic [3:0] S_HALTED    = 4'd6;
    localparam logic [3:0] S_FAULT     = 4'd7;
`ifdef SEQ_SINGLE_STEP_EN
    localparam logic [3:0] S_PAUSE     = 4'd8;
`endif

    localparam logic [3:0] MAX_N = 4'(MAX_UOPS);
    localparam logic [7:0] TMO   = 8'(FETCH_TIMEOUT);

    logic [3:0]       state_q, state_d;
    logic             uop_sel_q, uop_sel_d;
    logic [3:0]       uop_cnt_q, uop_cnt_d;
    logic [7:0]       wait_q, wait_d;
    logic [RET_W-1:0] ret_q, ret_d;
    logic [3:0]       n_eff;
    logic             last_uop;

    // Writeback is the last one once the next micro-op index would reach the count.
    assign last_uop = ({3'b000, uop_sel_q} + 4'd1) >= uop_cnt_q;

    always_comb begin
        state_d   = state_q;
        uop_sel_d = uop_sel_q;
        uop_cnt_d = uop_cnt_q;
        wait_d    = wait_q;
        ret_d     = ret_q;
        n_eff     = uop_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = bus.halt_req ? S_HALTED : S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                    wait_d  = 8'd0;
                end else if (wait_q >= TMO) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d   = S_SELECT;
                uop_sel_d = 1'b0;
            end
            S_SELECT: begin
                // First micro-op samples the count decode produced last cycle.
                if (!uop_sel_q) begin
                    n_eff     = bus.num_of_ope;
                    uop_cnt_d = bus.num_of_ope;
                end
                if (n_eff == 4'd0 || n_eff > MAX_N) state_d = S_FAULT;
                else                                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (!last_uop) begin
                    uop_sel_d = 1'b1;
                    state_d   = S_SELECT;
                end else begin
                    ret_d     = ret_q + RET_W'(1);
                    uop_sel_d = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                    state_d   = bus.halt_req ? S_HALTED : S_PAUSE;
`else
                    state_d   = bus.halt_req ? S_HALTED : S_FETCH;
`endif
                end
            end
            S_HALTED: begin
                if (!bus.halt_req) state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (bus.halt_req)      state_d = S_HALTED;
                else if (bus.step_req) state_d = S_FETCH;
            end
`endif
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            uop_sel_q <= 1'b0;
            uop_cnt_q <= 4'd0;
            wait_q    <= 8'd0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            uop_sel_q <= uop_sel_d;
            uop_cnt_q <= uop_cnt_d;
            wait_q    <= wait_d;
            ret_q     <= ret_d;
        end
    end

    assign bus.fetch_en    = (state_q == S_FETCH);
    assign bus.decode_en   = (state_q == S_DECODE);
    assign bus.select_en   = (state_q == S_SELECT);
    assign bus.exec_en     = (state_q == S_EXECUTE);
    assign bus.wb_en       = (state_q == S_WRITEBACK);
    assign bus.retire      = (state_q == S_WRITEBACK) && last_uop;
    assign bus.uop_sel     = uop_sel_q;
    assign bus.retired_cnt = ret_q;
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.fault       = (state_q == S_FAULT);
endmodule
